// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between an AES cipher host and aes_round_ctrl.
// The decrypt member exists only when AES_DECRYPT_EN is defined.
interface aes_round_ctrl_if;
`ifdef AES_DECRYPT_EN
  logic       decrypt;
`endif
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [3:0] round;
  logic       init_ld;
  logic       round_ld;
  logic       mix_col_en;
  logic       key_step;

  modport master (
`ifdef AES_DECRYPT_EN
    output decrypt,
`endif
    output start, abort,
    input  busy, done, round, init_ld, round_ld, mix_col_en, key_step
  );

  modport slave (
`ifdef AES_DECRYPT_EN
    input  decrypt,
`endif
    input  start, abort,
    output busy, done, round, init_ld, round_ld, mix_col_en, key_step
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer: drives selects/enables for the shared round datapath.
// Optional inverse-cipher round ordering is compiled in with `define AES_DECRYPT_EN.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int SUB_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.slave  ctl
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_SUB_WAIT = 3'd2,
    S_ROUND_LD = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] NR_V      = 4'(NR);
  localparam bit         HAS_WAIT  = (SUB_LAT > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(SUB_LAT - 1) : 4'd0;
  localparam state_t     AFTER_LD  = HAS_WAIT ? S_SUB_WAIT : S_ROUND_LD;

  state_t     state_r;
  logic [3:0] round_r;
  logic [3:0] wait_r;
  logic       dec_s;
  logic [3:0] start_round_s;
  logic       last_round_s;
  logic [3:0] step_round_s;

`ifdef AES_DECRYPT_EN
  logic dec_r;
  assign dec_s         = dec_r;
  assign start_round_s = ctl.decrypt ? NR_V : 4'd0;
`else
  assign dec_s         = 1'b0;
  assign start_round_s = 4'd0;
`endif

  // The final round is the one whose capture skips MixColumns and ends the run.
  assign last_round_s = dec_s ? (round_r == 4'd0) : (round_r == NR_V);
  assign step_round_s = dec_s ? (round_r - 4'd1) : (round_r + 4'd1);

  // Sequencer state, round index and S-box latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      round_r <= 4'd0;
      wait_r  <= 4'd0;
`ifdef AES_DECRYPT_EN
      dec_r   <= 1'b0;
`endif
    end else if (ctl.abort) begin
      state_r <= S_IDLE;
      round_r <= 4'd0;
      wait_r  <= 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (ctl.start) begin
            state_r <= S_INIT;
            round_r <= start_round_s;
`ifdef AES_DECRYPT_EN
            dec_r   <= ctl.decrypt;
`endif
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_INIT: begin
          round_r <= step_round_s;
          wait_r  <= WAIT_LOAD;
          state_r <= AFTER_LD;
        end
        S_SUB_WAIT: begin
          if (wait_r == 4'd0) begin
            state_r <= S_ROUND_LD;
          end else begin
            wait_r  <= wait_r - 4'd1;
          end
        end
        S_ROUND_LD: begin
          if (last_round_s) begin
            state_r <= S_DONE;
          end else begin
            round_r <= step_round_s;
            wait_r  <= WAIT_LOAD;
            state_r <= AFTER_LD;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          round_r <= 4'd0;
        end
        default: begin
          state_r <= S_IDLE;
          round_r <= 4'd0;
          wait_r  <= 4'd0;
        end
      endcase
    end
  end

  // Outputs decode the registered state only, so reset clears them without a clock.
  assign ctl.busy       = (state_r != S_IDLE);
  assign ctl.done       = (state_r == S_DONE);
  assign ctl.init_ld    = (state_r == S_INIT);
  assign ctl.round_ld   = (state_r == S_ROUND_LD);
  assign ctl.key_step   = (state_r == S_ROUND_LD);
  assign ctl.mix_col_en = (state_r == S_ROUND_LD) && !last_round_s;
  assign ctl.round      = round_r;

endmodule
